// File: rtl/bster_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bster_pkg                                                        |
// | Brief   : Shared types for the BST engine slice: allocator FSM states,     |
// |           pool depth helper and engine command codes.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bster_pkg;

    typedef enum logic [0:0] {
        TSM_INIT  = 1'b0,
        TSM_READY = 1'b1
    } tsm_state_t;

    typedef enum logic [1:0] {
        BST_CMD_NOP    = 2'd0,
        BST_CMD_INSERT = 2'd1,
        BST_CMD_DELETE = 2'd2,
        BST_CMD_SEARCH = 2'd3
    } bst_cmd_t;

    function automatic int unsigned tsm_depth(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage : bster_pkg
`default_nettype wire

// File: rtl/tree_space_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tree_space_fifo                                                  |
// | Brief   : Free-list FIFO, synchronous write, combinational read, wrap-bit  |
// |           pointers and a registered occupancy count.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tree_space_fifo
    import bster_pkg::*;
#(
    parameter int TOKEN_WIDTH = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   push,
    input  logic [TOKEN_WIDTH-1:0] push_data,
    input  logic                   pop,
    output logic [TOKEN_WIDTH-1:0] rd_data,
    output logic [TOKEN_WIDTH:0]   count
);

    localparam int DEPTH = tsm_depth(TOKEN_WIDTH);

    logic [TOKEN_WIDTH-1:0] r_mem [DEPTH];
    logic [TOKEN_WIDTH:0]   r_rd_ptr;
    logic [TOKEN_WIDTH:0]   r_wr_ptr;
    logic [TOKEN_WIDTH:0]   r_count;

    // Storage is deliberately not reset; only pointers and count carry state.
    always_ff @(posedge aclk) begin
        if (push) begin
            r_mem[r_wr_ptr[TOKEN_WIDTH-1:0]] <= push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr[TOKEN_WIDTH-1:0]];
    assign count   = r_count;

endmodule : tree_space_fifo
`default_nettype wire

// File: rtl/tree_space_manager.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tree_space_manager                                               |
// | Brief   : Tree node address allocator: init fill, pop on request, push on  |
// |           release. Optional double-free check: TREE_SPACE_DFREE_CHK_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tree_space_manager
    import bster_pkg::*;
#(
    parameter int TOKEN_WIDTH = 8,
    parameter int INIT_BASE   = 0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [TOKEN_WIDTH-1:0] req_addr,
    input  logic                   free_valid,
    output logic                   free_ready,
    input  logic [TOKEN_WIDTH-1:0] free_addr,
    output logic                   full,
    output logic [TOKEN_WIDTH:0]   free_count,
    output logic                   init_done,
    output logic                   err_double_free
);

    localparam int                     DEPTH       = tsm_depth(TOKEN_WIDTH);
    localparam logic [TOKEN_WIDTH:0]   c_depth     = DEPTH[TOKEN_WIDTH:0];
    localparam logic [TOKEN_WIDTH-1:0] c_init_base = INIT_BASE[TOKEN_WIDTH-1:0];
    localparam logic [TOKEN_WIDTH-1:0] c_init_last = {TOKEN_WIDTH{1'b1}};

    tsm_state_t             r_state;
    tsm_state_t             w_state_nxt;
    logic [TOKEN_WIDTH-1:0] r_init_cnt;
    logic                   r_init_done;

    logic                   w_fifo_push;
    logic [TOKEN_WIDTH-1:0] w_fifo_data;
    logic                   w_fifo_pop;
    logic [TOKEN_WIDTH-1:0] w_head;
    logic [TOKEN_WIDTH:0]   w_count;

    logic                   w_req_ready;
    logic                   w_free_ready;
    logic                   w_full;
    logic                   w_pop_fire;
    logic                   w_push_fire;
    logic                   w_push_ok;

    tree_space_fifo #(
        .TOKEN_WIDTH(TOKEN_WIDTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (w_fifo_push),
        .push_data (w_fifo_data),
        .pop       (w_fifo_pop),
        .rd_data   (w_head),
        .count     (w_count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= TSM_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == TSM_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (r_init_cnt == c_init_last) begin
                    r_init_done <= 1'b1;
                end
            end
        end
    end

    assign w_pop_fire  = req_valid && w_req_ready;
    assign w_push_fire = free_valid && w_free_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_free_ready = 1'b0;
        w_full       = 1'b1;
        w_fifo_push  = 1'b0;
        w_fifo_pop   = 1'b0;
        w_fifo_data  = free_addr;
        case (r_state)
            TSM_INIT: begin
                w_fifo_push = 1'b1;
                w_fifo_data = c_init_base + r_init_cnt;
                if (r_init_cnt == c_init_last) begin
                    w_state_nxt = TSM_READY;
                end
            end
            TSM_READY: begin
                w_req_ready  = (w_count != '0);
                w_free_ready = (w_count != c_depth);
                w_full       = (w_count == '0);
                w_fifo_pop   = w_pop_fire;
                w_fifo_push  = w_push_fire && w_push_ok;
            end
            default: w_state_nxt = TSM_INIT;
        endcase
    end

`ifdef TREE_SPACE_DFREE_CHK_EN
    logic [DEPTH-1:0] r_alloc;
    logic             r_err;

    // A release is only legal for an address currently handed out.
    assign w_push_ok = r_alloc[free_addr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_alloc <= '0;
            r_err   <= 1'b0;
        end else if (r_state == TSM_INIT) begin
            r_alloc <= '0;
        end else begin
            if (w_push_fire && w_push_ok) begin
                r_alloc[free_addr] <= 1'b0;
            end
            if (w_pop_fire) begin
                r_alloc[w_head] <= 1'b1;
            end
            if (w_push_fire && !w_push_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_double_free = r_err;
`else
    assign w_push_ok       = 1'b1;
    assign err_double_free = 1'b0;
`endif

    assign req_ready  = w_req_ready;
    assign free_ready = w_free_ready;
    assign full       = w_full;
    // Zero-latency head for the engine; masked so an empty list never leaks stale data.
    assign req_addr   = w_full ? '0 : w_head;
    assign free_count = w_count;
    assign init_done  = r_init_done;

endmodule : tree_space_manager
`default_nettype wire
